// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// PC register and instruction-fetch stage of the MIPS pipeline. It holds the
// current fetch PC, issues instruction-memory requests, and loads the IF/ID
// pipeline register. ID-stage stalls are absorbed by a one-entry hold buffer,
// and flushes redirect fetch to a new target.
//
// Optional feature (macro FETCH_ADEL_EN):
//   Adds the id_adel output. A misaligned PC (pc[1:0] != 0) never reaches
//   memory. Instead the stage fabricates a NOP tagged with an address-error
//   flag that travels down the pipe with the instruction.
//
// Parameters:
//   RESET_PC   PC loaded on reset
//   NOP_INSTR  instruction word shown on id_instr whenever id_valid = 0
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        synchronous active-high reset
//   npc          next PC from the next-PC logic, sampled on an advance
//   pc           current fetch PC
//   imem_req     fetch request (FETCH state only)
//   imem_addr    fetch address, always equal to pc
//   imem_ready   memory returns imem_rdata this cycle
//   imem_rdata   instruction word from memory
//   stall        ID stage cannot accept a new instruction
//   flush        squash IF/ID and redirect fetch to flush_pc
//   flush_pc     redirect target
//   id_valid     IF/ID holds a live instruction
//   id_instr     IF/ID instruction
//   id_pc        PC of id_instr
//   id_adel      (FETCH_ADEL_EN only) address-error tag of id_instr
//   id_pc8       id_pc + 8, the link address
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
`ifdef FETCH_ADEL_EN
  output logic        id_adel,
`endif
  output logic [31:0] id_pc8
);

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]  state;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;

  // Signals describing the instruction available to this cycle's fetch
  logic        fetch_hit;
  logic [31:0] fetch_instr;

  // Signals describing what would be loaded into IF/ID on an advance
  logic        do_advance;
  logic [31:0] adv_instr;
  logic [31:0] adv_pc;

`ifdef FETCH_ADEL_EN
  logic        hold_adel;
  logic        misaligned;
  logic        adv_adel;
`endif

  assign imem_addr = pc;

  // A misaligned PC behaves like an instant memory response carrying a NOP.
  // That way the stall/hold logic below does not need a special case.
  always_comb begin
`ifdef FETCH_ADEL_EN
    misaligned  = (pc[1:0] != 2'b00);
    fetch_hit   = imem_ready | misaligned;
    fetch_instr = misaligned ? NOP_INSTR : imem_rdata;
    imem_req    = (state == ST_FETCH) && !misaligned;
`else
    fetch_hit   = imem_ready;
    fetch_instr = imem_rdata;
    imem_req    = (state == ST_FETCH);
`endif
  end

  // An advance drains the hold buffer if it is full. Otherwise it takes the
  // fresh fetch. Either way it needs the ID stage to be accepting.
  always_comb begin
    do_advance = !stall && ((state == ST_HOLD) || fetch_hit);
    adv_instr  = (state == ST_HOLD) ? hold_instr : fetch_instr;
    adv_pc     = (state == ST_HOLD) ? hold_pc    : pc;
`ifdef FETCH_ADEL_EN
    adv_adel   = (state == ST_HOLD) ? hold_adel  : misaligned;
`endif
  end

  // Main state update. Reset beats flush, and flush beats stall and
  // memory ready. A flush discards both the hold buffer and any
  // instruction returning this cycle. The hold buffer is implicitly
  // empty whenever state is FETCH, so its contents need no clearing.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      state      <= ST_FETCH;
      id_valid   <= 1'b0;
      id_instr   <= NOP_INSTR;
      id_pc      <= 32'h0;
      id_pc8     <= 32'h0;
      hold_instr <= NOP_INSTR;
      hold_pc    <= 32'h0;
`ifdef FETCH_ADEL_EN
      id_adel    <= 1'b0;
      hold_adel  <= 1'b0;
`endif
    end else if (flush) begin
      pc       <= flush_pc;
      state    <= ST_FETCH;
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
`ifdef FETCH_ADEL_EN
      id_adel  <= 1'b0;
`endif
    end else if (do_advance) begin
      id_valid <= 1'b1;
      id_instr <= adv_instr;
      id_pc    <= adv_pc;
      id_pc8   <= adv_pc + 32'd8;
      pc       <= npc;
      state    <= ST_FETCH;
`ifdef FETCH_ADEL_EN
      id_adel  <= adv_adel;
`endif
    end else if (state == ST_FETCH) begin
      if (fetch_hit) begin
        // Only reachable with stall=1: park the word until ID frees up.
        hold_instr <= fetch_instr;
        hold_pc    <= pc;
        state      <= ST_HOLD;
`ifdef FETCH_ADEL_EN
        hold_adel  <= misaligned;
`endif
      end else if (!stall) begin
        // Nothing fetched and ID is ready: insert a bubble.
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
`ifdef FETCH_ADEL_EN
        id_adel  <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Scoreboard testbench for fetch_stage. The stimulus process drives one cycle
// of inputs and pushes the state expected after the next rising edge. The
// monitor process pops one entry on every falling edge and compares it with
// what the DUT presents.
// Define FETCH_ADEL_EN for both the bench and the DUT to cover the
// address-error variant.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] npc;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;
`ifdef FETCH_ADEL_EN
  logic        id_adel;
  localparam bit ADEL = 1'b1;
`else
  localparam bit ADEL = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        req;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] ipc8;
    logic        adel;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .npc        (npc),
    .pc         (pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
`ifdef FETCH_ADEL_EN
    .id_adel    (id_adel),
`endif
    .id_pc8     (id_pc8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input string field,
                              input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s.%s got %h expected %h", name, field, act, req);
    end
  endtask

  // Drive one cycle of inputs, record the expected post-edge state, and
  // return just after the following falling edge.
  task automatic apply_stimulus(
      input string name, input logic rst, input logic rdy,
      input logic [31:0] rdata, input logic stl, input logic fl,
      input logic [31:0] fpc, input logic [31:0] nv,
      input logic [31:0] e_pc, input logic e_req, input logic e_valid,
      input logic [31:0] e_instr, input logic [31:0] e_ipc,
      input logic [31:0] e_ipc8, input logic e_adel);
    exp_t e;
    reset      = rst;
    imem_ready = rdy;
    imem_rdata = rdata;
    stall      = stl;
    flush      = fl;
    flush_pc   = fpc;
    npc        = nv;
    e.name  = name;
    e.pc    = e_pc;
    e.req   = e_req;
    e.valid = e_valid;
    e.instr = e_instr;
    e.ipc   = e_ipc;
    e.ipc8  = e_ipc8;
    e.adel  = e_adel;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // Monitor: compare every presented cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e.name, "pc",        pc,                e.pc);
        check_output(e.name, "imem_addr", imem_addr,         e.pc);
        check_output(e.name, "imem_req",  {31'h0, imem_req}, {31'h0, e.req});
        check_output(e.name, "id_valid",  {31'h0, id_valid}, {31'h0, e.valid});
        check_output(e.name, "id_instr",  id_instr,          e.instr);
        check_output(e.name, "id_pc",     id_pc,             e.ipc);
        check_output(e.name, "id_pc8",    id_pc8,            e.ipc8);
`ifdef FETCH_ADEL_EN
        check_output(e.name, "id_adel",   {31'h0, id_adel},  {31'h0, e.adel});
`endif
      end
    end
  end

  initial begin
    int budget;
    reset = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
    stall = 1'b0; flush = 1'b0; flush_pc = 32'h0; npc = 32'h0;

    //              name          rst rdy rdata          stl fl  fpc            npc            | pc           req v  instr          id_pc          id_pc8         adel
    apply_stimulus("reset",       1, 0, 32'h0,          0, 0, 32'h0,         32'h0,         32'h0000_3000, 1, 0, 32'h0,         32'h0,         32'h0,         0);
    apply_stimulus("run0",        0, 1, 32'h1111_0000,  0, 0, 32'h0,         32'h0000_3004, 32'h0000_3004, 1, 1, 32'h1111_0000, 32'h0000_3000, 32'h0000_3008, 0);
    apply_stimulus("stall_cap",   0, 1, 32'h2408_0001,  1, 0, 32'h0,         32'hDEAD_0000, 32'h0000_3004, 0, 1, 32'h1111_0000, 32'h0000_3000, 32'h0000_3008, 0);
    apply_stimulus("hold1",       0, 1, 32'h9999_9999,  1, 0, 32'h0,         32'hDEAD_0004, 32'h0000_3004, 0, 1, 32'h1111_0000, 32'h0000_3000, 32'h0000_3008, 0);
    apply_stimulus("hold2",       0, 0, 32'h0,          1, 0, 32'h0,         32'hDEAD_0008, 32'h0000_3004, 0, 1, 32'h1111_0000, 32'h0000_3000, 32'h0000_3008, 0);
    apply_stimulus("hold_rel",    0, 0, 32'hBAD0_BAD0,  0, 0, 32'h0,         32'h0000_3008, 32'h0000_3008, 1, 1, 32'h2408_0001, 32'h0000_3004, 32'h0000_300C, 0);
    apply_stimulus("bubble1",     0, 0, 32'h1234_5678,  0, 0, 32'h0,         32'hDEAD_000C, 32'h0000_3008, 1, 0, 32'h0,         32'h0000_3004, 32'h0000_300C, 0);
    apply_stimulus("bubble2",     0, 0, 32'h1234_5678,  0, 0, 32'h0,         32'hDEAD_0010, 32'h0000_3008, 1, 0, 32'h0,         32'h0000_3004, 32'h0000_300C, 0);
    apply_stimulus("run1",        0, 1, 32'h3333_0000,  0, 0, 32'h0,         32'h0000_300C, 32'h0000_300C, 1, 1, 32'h3333_0000, 32'h0000_3008, 32'h0000_3010, 0);
    apply_stimulus("stall_idle",  0, 0, 32'h0,          1, 0, 32'h0,         32'hDEAD_0014, 32'h0000_300C, 1, 1, 32'h3333_0000, 32'h0000_3008, 32'h0000_3010, 0);
    apply_stimulus("stall_cap2",  0, 1, 32'h4444_0000,  1, 0, 32'h0,         32'hDEAD_0018, 32'h0000_300C, 0, 1, 32'h3333_0000, 32'h0000_3008, 32'h0000_3010, 0);
    apply_stimulus("flush_hold",  0, 1, 32'h5555_0000,  1, 1, 32'h0000_4180, 32'hDEAD_001C, 32'h0000_4180, 1, 0, 32'h0,         32'h0000_3008, 32'h0000_3010, 0);
    apply_stimulus("after_flush", 0, 1, 32'h6666_0000,  0, 0, 32'h0,         32'h0000_4184, 32'h0000_4184, 1, 1, 32'h6666_0000, 32'h0000_4180, 32'h0000_4188, 0);
    apply_stimulus("flush_fetch", 0, 1, 32'h7777_0000,  0, 1, 32'hFFFF_FFFC, 32'hDEAD_0020, 32'hFFFF_FFFC, 1, 0, 32'h0,         32'h0000_4180, 32'h0000_4188, 0);
    apply_stimulus("wrap",        0, 1, 32'h8888_0000,  0, 0, 32'h0,         32'h0000_0000, 32'h0000_0000, 1, 1, 32'h8888_0000, 32'hFFFF_FFFC, 32'h0000_0004, 0);
    apply_stimulus("stall_cap3",  0, 1, 32'h9999_0000,  1, 0, 32'h0,         32'hDEAD_0024, 32'h0000_0000, 0, 1, 32'h8888_0000, 32'hFFFF_FFFC, 32'h0000_0004, 0);
    apply_stimulus("reset_mid",   1, 1, 32'hAAAA_AAAA,  1, 1, 32'h0000_5000, 32'hDEAD_0028, 32'h0000_3000, 1, 0, 32'h0,         32'h0,         32'h0,         0);
    apply_stimulus("run2",        0, 1, 32'hAAAA_0000,  0, 0, 32'h0,         32'h0000_3004, 32'h0000_3004, 1, 1, 32'hAAAA_0000, 32'h0000_3000, 32'h0000_3008, 0);

    // Redirect to a misaligned target. With the address-error feature no
    // request is issued and a tagged NOP advances. Without it the PC is
    // fetched normally and the idle memory just produces a bubble.
    apply_stimulus("flush_mis",   0, 0, 32'h0,          0, 1, 32'h0000_3002, 32'hDEAD_002C, 32'h0000_3002, !ADEL, 0, 32'h0,   32'h0000_3000, 32'h0000_3008, 0);
    if (ADEL)
      apply_stimulus("adel_adv",  0, 0, 32'hCCCC_0000,  0, 0, 32'h0,         32'h0000_3006, 32'h0000_3006, 0, 1, 32'h0,         32'h0000_3002, 32'h0000_300A, 1);
    else
      apply_stimulus("mis_bubble",0, 0, 32'hCCCC_0000,  0, 0, 32'h0,         32'h0000_3006, 32'h0000_3002, 1, 0, 32'h0,         32'h0000_3000, 32'h0000_3008, 0);
    if (ADEL)
      apply_stimulus("adel_flush",0, 0, 32'h0,          0, 1, 32'h0000_3010, 32'hDEAD_0030, 32'h0000_3010, 1, 0, 32'h0,         32'h0000_3002, 32'h0000_300A, 0);
    else
      apply_stimulus("mis_flush", 0, 0, 32'h0,          0, 1, 32'h0000_3010, 32'hDEAD_0030, 32'h0000_3010, 1, 0, 32'h0,         32'h0000_3000, 32'h0000_3008, 0);

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain got %0d pending expected 0 pending", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
